// File: rtl/serial_word_loader_pkg.sv
// Shared definitions for the serial boot loader: FSM state encoding and default parameters,
// reused by the loader, its bench and the board wrapper.
package serial_word_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN,
      ST_DATA,
      ST_CSUM,
      ST_DONE,
      ST_ERROR
   } loader_state_t;

   localparam int DEF_WORD_W      = 32;
   localparam int DEF_ADDR_W      = 12;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_TIMEOUT_CYC = 100000;
   localparam int DEF_CHECKSUM_EN = 1;
   localparam int DEF_MSB_FIRST   = 1;

   function automatic logic in_frame(input loader_state_t s);
      return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM);
   endfunction

endpackage

// File: rtl/serial_word_loader_pin_sync.sv
// N-stage synchroniser for an asynchronous boot pin, with a rising-edge pulse on the
// synchronised level (one core cycle wide).
module pin_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic pin,
   output logic level,
   output logic rise
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], pin};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign level = sync_q[STAGES-1];
   assign rise  = level & ~prev_q;

endmodule

// File: rtl/serial_word_loader.sv
// Serial boot loader: assembles length-framed words from the host bit clock/data pins and
// writes the payload to instruction memory at incrementing addresses, with checksum and timeout.
module serial_word_loader
   import serial_word_loader_pkg::*;
#(
   parameter int WORD_W      = DEF_WORD_W,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int CHECKSUM_EN = DEF_CHECKSUM_EN,
   parameter int MSB_FIRST   = DEF_MSB_FIRST
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              arm,
   input  logic              ser_clk,
   input  logic              ser_data,
   output logic              ready,
   output logic              busy,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WORD_W-1:0] wr_data,
   output logic [ADDR_W:0]   words_done,
   output logic              done,
   output logic              error
);

   localparam int CNT_W = $clog2(WORD_W) + 1;
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WORD_W - 1);
   localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
   localparam logic [WORD_W:0]   MAX_LEN  = {{WORD_W{1'b0}}, 1'b1} << ADDR_W;

   loader_state_t     state, state_next;
   logic [CNT_W-1:0]  bit_cnt;
   logic [WORD_W-1:0] shift_reg, new_word, sum;
   logic [TMO_W-1:0]  tmo_cnt;
   logic [ADDR_W:0]   len_target, words_inc;
   logic              clk_rise, clk_lvl, data_lvl, data_rise;
   logic              accept, word_done, tmo_hit, last_word;
   logic              unused_sync_outputs;

   pin_sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (
      .clock (clock),
      .reset (reset),
      .pin   (ser_clk),
      .level (clk_lvl),
      .rise  (clk_rise)
   );

   pin_sync_edge #(.STAGES(SYNC_STAGES)) u_data_sync (
      .clock (clock),
      .reset (reset),
      .pin   (ser_data),
      .level (data_lvl),
      .rise  (data_rise)
   );

   // Only the clock edge and the data level matter; the other two taps are intentionally dropped.
   assign unused_sync_outputs = &{1'b0, clk_lvl, data_rise};

   always_comb begin
      new_word   = (MSB_FIRST != 0) ? {shift_reg[WORD_W-2:0], data_lvl}
                                    : {data_lvl, shift_reg[WORD_W-1:1]};
      accept     = arm && clk_rise && ((state == ST_IDLE) || in_frame(state));
      word_done  = accept && (bit_cnt == LAST_BIT);
      words_inc  = words_done + 1'b1;
      last_word  = (words_inc == len_target);
      tmo_hit    = in_frame(state) && !clk_rise && (tmo_cnt == TMO_LAST);
      state_next = state;
      case (state)
         ST_IDLE: if (accept) state_next = ST_LEN;
         ST_LEN: begin
            if (word_done) begin
               if ({1'b0, new_word} > MAX_LEN)
                  state_next = ST_ERROR;
               else if (new_word == '0)
                  state_next = (CHECKSUM_EN != 0) ? ST_CSUM : ST_DONE;
               else
                  state_next = ST_DATA;
            end
         end
         ST_DATA: begin
            if (word_done && last_word)
               state_next = (CHECKSUM_EN != 0) ? ST_CSUM : ST_DONE;
         end
         ST_CSUM: if (word_done) state_next = (new_word == sum) ? ST_DONE : ST_ERROR;
         default: state_next = state;
      endcase
      if (tmo_hit)
         state_next = ST_ERROR;
   end

   // Dropping arm abandons the frame outright: partial words and status are discarded.
   always_ff @(posedge clock) begin
      if (reset || !arm) begin
         state      <= ST_IDLE;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         sum        <= '0;
         tmo_cnt    <= '0;
         len_target <= '0;
         words_done <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
      end else begin
         state <= state_next;
         wr_en <= 1'b0;
         if (accept) begin
            shift_reg <= new_word;
            bit_cnt   <= word_done ? '0 : bit_cnt + 1'b1;
         end
         tmo_cnt <= (in_frame(state) && !clk_rise) ? tmo_cnt + 1'b1 : '0;
         if (state == ST_IDLE && accept) begin
            words_done <= '0;
            sum        <= '0;
         end
         if (state == ST_LEN && word_done)
            len_target <= new_word[ADDR_W:0];
         if (state == ST_DATA && word_done) begin
            wr_en      <= 1'b1;
            wr_addr    <= words_done[ADDR_W-1:0];
            wr_data    <= new_word;
            sum        <= sum + new_word;
            words_done <= words_inc;
         end
      end
   end

   assign ready = (state == ST_IDLE) && arm && !reset;
   assign busy  = in_frame(state);
   assign done  = (state == ST_DONE);
   assign error = (state == ST_ERROR);

endmodule
